// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the elastic pipeline stage register.
// State encoding doubles as the occupancy count.
package pipe_stage_skid_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_e s);
    logic [PIPE_OCC_W-1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready stage register with optional 2-entry skid buffer.
// Priority per cycle: rst > flush > handshake.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W    = 192,
  parameter bit REG_READY = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              valid_int;
  logic              in_fire;
  logic              out_fire;

  assign valid_int = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = valid_int & out_ready;

  // Main always holds the oldest entry, so the skid can never overtake it.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            if (REG_READY) begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (REG_READY) begin : g_skid
      logic in_ready_q;

      // in_ready is registered from next state, cutting any out_ready->in_ready path.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else begin
          skid_q     <= skid_d;
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      logic unused_skid;

      assign skid_q      = '0;
      assign unused_skid = ^skid_d;
      assign in_ready    = out_ready | ~valid_int;
    end
  endgenerate

  assign out_valid = valid_int;
  assign out_data  = valid_int ? main_q : '0;
  assign occupancy = occ_of(state_q);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .en  (valid_int & ~out_ready),
    .clr (rst),
    .q   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: a skid instance (CNT_W=4) and a no-skid instance share stimulus,
// each compared every cycle against its own FIFO model.
module tb_pipe_stage_skid;

  localparam int DW = 192;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready1, out_valid1;
  logic [DW-1:0] out_data1;
  logic [1:0]    occ1;
  logic [3:0]    stall1;

  logic          in_ready0, out_valid0;
  logic [DW-1:0] out_data0;
  logic [1:0]    occ0;
  logic [15:0]   stall0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  int unsigned   exp_stall1 = 0;
  int unsigned   exp_stall0 = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .REG_READY(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1), .stall_cnt(stall1)
  );

  pipe_stage_skid #(.DATA_W(DW), .REG_READY(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0), .stall_cnt(stall0)
  );

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle, check both DUTs mid-cycle against the models, then advance the models.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                               input logic fl, input logic rs);
    logic [DW-1:0] exp_d;
    logic          rdy1, rdy0;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(negedge clk);

    rdy1  = (q1.size() < 2);
    exp_d = (q1.size() > 0) ? q1[0] : '0;
    checkOutput("skid.out_valid", DW'(out_valid1), DW'(q1.size() > 0));
    checkOutput("skid.out_data", out_data1, exp_d);
    checkOutput("skid.occupancy", DW'(occ1), DW'(q1.size()));
    checkOutput("skid.in_ready", DW'(in_ready1), DW'(rdy1));
    checkOutput("skid.stall_cnt", DW'(stall1), DW'(exp_stall1));

    rdy0  = ordy | (q0.size() == 0);
    exp_d = (q0.size() > 0) ? q0[0] : '0;
    checkOutput("noskid.out_valid", DW'(out_valid0), DW'(q0.size() > 0));
    checkOutput("noskid.out_data", out_data0, exp_d);
    checkOutput("noskid.occupancy", DW'(occ0), DW'(q0.size()));
    checkOutput("noskid.in_ready", DW'(in_ready0), DW'(rdy0));
    checkOutput("noskid.stall_cnt", DW'(stall0), DW'(exp_stall0));

    if (rs) begin
      q1.delete();
      q0.delete();
      exp_stall1 = 0;
      exp_stall0 = 0;
    end else begin
      if (q1.size() > 0 && !ordy && exp_stall1 < 15) exp_stall1++;
      if (q0.size() > 0 && !ordy && exp_stall0 < 65535) exp_stall0++;
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (fl) begin
        q1.delete();
        q0.delete();
      end else begin
        if (iv && rdy1) q1.push_back(d);
        if (iv && rdy0) q0.push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] a, b, c;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] stream 1..8");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] back-pressure");
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] flush while full");
    applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, c, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, c, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] stall counter saturation");
    applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] no-skid reload");
    applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, rnd_data(), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), rnd_data(),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);
    end
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
